scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_ctrl_pkg.sv | 21 ++
 rtl/scan_chain_ctrl_if.sv | 25 ++
 rtl/scan_chain_shreg.sv | 31 +++
 rtl/scan_chain_ctrl.sv | 168 ++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and constants for the scan chain controller: FSM states,
// legal chain-length range and the bit-counter width helper.
package scan_chain_ctrl_pkg;

    localparam int CHAIN_LEN_MIN = 2;
    localparam int CHAIN_LEN_MAX = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_IN = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_UNLOAD   = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // Wide enough to hold CHAIN_LEN itself, so the counter never needs to wrap.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Operation request/response bus of the scan chain controller.
// SCAN_CHAIN_CTRL_COMPARE_EN adds the expected-response input and mismatch flag.
interface scan_chain_ctrl_if #(parameter int CHAIN_LEN = 16);

    logic                 start;
    logic [CHAIN_LEN-1:0] load_data;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] unload_data;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] expect_data;
    logic                 mismatch;

    modport master (output start, output load_data, output expect_data,
                    input busy, input done, input unload_data, input mismatch);
    modport slave  (input start, input load_data, input expect_data,
                    output busy, output done, output unload_data, output mismatch);
`else
    modport master (output start, output load_data,
                    input busy, input done, input unload_data);
    modport slave  (input start, input load_data,
                    output busy, output done, output unload_data);
`endif

endinterface

// File: rtl/scan_chain_shreg.sv
// Parallel-load shift register: shifts toward the MSB, serial data enters at bit 0.
module scan_chain_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Load has priority over shift; reset clears the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (ld) begin
            q_r <= d;
        end else if (sh) begin
            q_r <= {q_r[WIDTH-2:0], sin};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shift a pattern in, capture one cycle, shift the response out.
// Optional response compare is enabled with SCAN_CHAIN_CTRL_COMPARE_EN.
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    scan_chain_ctrl_if.slave bus,
    output logic             se,
    output logic             si,
    input  logic             so
);

    localparam int              CW       = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CHAIN_LEN - 1);

    if (CHAIN_LEN < CHAIN_LEN_MIN || CHAIN_LEN > CHAIN_LEN_MAX) begin : g_bad_len
        $error("scan_chain_ctrl: CHAIN_LEN out of range");
    end

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic                 se_r;
    logic                 si_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 accept_s;
    logic                 last_s;
    logic                 load_sh_s;
    logic                 unload_sh_s;
    logic [CHAIN_LEN-1:0] load_d_s;
    logic [CHAIN_LEN-1:0] load_q_s;
    logic [CHAIN_LEN-1:0] unload_q_s;
    logic                 unused_load_s;

    // Decode shift-register controls from the current state.
    always_comb begin
        accept_s    = ((state_r == ST_IDLE) || (state_r == ST_FINISH)) && bus.start;
        last_s      = (cnt_r == CNT_LAST);
        load_sh_s   = (state_r == ST_SHIFT_IN);
        unload_sh_s = (state_r == ST_UNLOAD);
        // The MSB goes straight to SI at accept, so the register holds the remaining bits.
        load_d_s    = {bus.load_data[CHAIN_LEN-2:0], 1'b0};
    end

    scan_chain_shreg #(.WIDTH(CHAIN_LEN)) u_load (
        .clk (clk),
        .rst (rst),
        .ld  (accept_s),
        .sh  (load_sh_s),
        .d   (load_d_s),
        .sin (1'b0),
        .q   (load_q_s)
    );

    scan_chain_shreg #(.WIDTH(CHAIN_LEN)) u_unload (
        .clk (clk),
        .rst (rst),
        .ld  (1'b0),
        .sh  (unload_sh_s),
        .d   ({CHAIN_LEN{1'b0}}),
        .sin (so),
        .q   (unload_q_s)
    );

    assign unused_load_s = &{1'b0, load_q_s[CHAIN_LEN-2:0]};

    // Operation sequencer with registered scan pins and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            se_r    <= 1'b0;
            si_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FINISH: begin
                    cnt_r  <= CNT_ZERO;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ST_SHIFT_IN;
                        se_r    <= 1'b1;
                        si_r    <= bus.load_data[CHAIN_LEN-1];
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        se_r    <= 1'b0;
                        si_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT_IN: begin
                    if (last_s) begin
                        state_r <= ST_CAPTURE;
                        cnt_r   <= CNT_ZERO;
                        se_r    <= 1'b0;
                        si_r    <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        si_r    <= load_q_s[CHAIN_LEN-1];
                    end
                end
                ST_CAPTURE: begin
                    state_r <= ST_UNLOAD;
                    cnt_r   <= CNT_ZERO;
                    se_r    <= 1'b1;
                    si_r    <= 1'b0;
                end
                ST_UNLOAD: begin
                    if (last_s) begin
                        state_r <= ST_FINISH;
                        cnt_r   <= CNT_ZERO;
                        se_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    se_r    <= 1'b0;
                    si_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign se              = se_r;
    assign si              = si_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.unload_data = unload_q_s;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] expect_r;
    logic                 mismatch_r;

    // Compare against the final unload word (including the last SO bit) as FINISH is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            expect_r   <= {CHAIN_LEN{1'b0}};
            mismatch_r <= 1'b0;
        end else if (accept_s) begin
            expect_r   <= bus.expect_data;
            mismatch_r <= mismatch_r;
        end else if ((state_r == ST_UNLOAD) && last_s) begin
            expect_r   <= expect_r;
            mismatch_r <= |({unload_q_s[CHAIN_LEN-2:0], so} ^ expect_r);
        end else begin
            expect_r   <= expect_r;
            mismatch_r <= mismatch_r;
        end
    end

    assign bus.mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl with an 8-flop chain whose functional D is ~Q.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic se, si, so;
    logic [N-1:0] chain = '0;

    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .se  (se),
        .si  (si),
        .so  (so)
    );

    // Scan chain model: flop 0 is fed by SI, flop N-1 drives SO.
    always @(posedge clk) begin
        if (se) chain <= {chain[N-2:0], si};
        else    chain <= ~chain;
    end
    assign so = chain[N-1];

    typedef struct {
        logic [N-1:0] data;
        logic         mm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = -1;
    int   prev_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DONE pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("unload_data", bus.unload_data, e.data);
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                    check("mismatch", bus.mismatch, e.mm);
`endif
                end
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
            end
        end
    end

    // One operation starting at the next edge; optional START pokes in busy cycles.
    task automatic run_op(input logic [N-1:0] ld, input logic [N-1:0] ex,
                          input logic [N-1:0] exp_ud, input logic exp_mm,
                          input int poke_a, input int poke_b);
        exp_t e;
        e.data = exp_ud;
        e.mm   = exp_mm;
        sb_q.push_back(e);
        bus.start     = 1'b1;
        bus.load_data = ld;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        bus.expect_data = ex;
`endif
        for (int c = 1; c <= 2*N+2; c++) begin
            tick();
            bus.start     = (c == poke_a) || (c == poke_b);
            bus.load_data = ~ld;
            if (c <= N) begin
                check("shift_se", se, 1'b1);
                check("shift_si", si, ld[N-c]);
                check("shift_busy", bus.busy, 1'b1);
                check("shift_done", bus.done, 1'b0);
            end else if (c == N+1) begin
                check("capture_se", se, 1'b0);
                check("capture_si", si, 1'b0);
                check("capture_busy", bus.busy, 1'b1);
            end else if (c <= 2*N+1) begin
                check("unload_se", se, 1'b1);
                check("unload_si", si, 1'b0);
                check("unload_busy", bus.busy, 1'b1);
                check("unload_done", bus.done, 1'b0);
            end else begin
                check("finish_done", bus.done, 1'b1);
                check("finish_busy", bus.busy, 1'b0);
                check("finish_se", se, 1'b0);
            end
        end
    endtask

    initial begin
        int d0;
        bus.start     = 1'b0;
        bus.load_data = '0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        bus.expect_data = '0;
`endif
        // Reset, with START asserted to confirm reset wins.
        rst = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        check("rst_se", se, 1'b0);
        check("rst_si", si, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_unload", bus.unload_data, 8'h00);
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        check("rst_mismatch", bus.mismatch, 1'b0);
`endif
        bus.start = 1'b0;
        rst = 1'b0;
        tick();

        // Normal operation.
        run_op(8'hA5, 8'h5A, 8'h5A, 1'b0, -1, -1);
        tick();
        check("hold_unload", bus.unload_data, 8'h5A);
        check("done_count_a", done_cnt, 1);

        // START while busy is ignored.
        run_op(8'hA5, 8'h5A, 8'h5A, 1'b0, 3, 12);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_busy", bus.busy, 1'b0);
            check("idle_done", bus.done, 1'b0);
        end
        check("done_count_b", done_cnt, 2);

        // Reset in the middle of SHIFT_IN aborts without DONE.
        bus.start     = 1'b1;
        bus.load_data = 8'hA5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("abort_se", se, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("done_count_abort", done_cnt, 2);
        run_op(8'h0F, 8'hF0, 8'hF0, 1'b0, -1, -1);

        // Back-to-back: the next run_op holds START high in the DONE cycle.
        run_op(8'hA5, 8'h5A, 8'h5A, 1'b0, -1, -1);
        d0 = done_cnt;
        run_op(8'h3C, 8'hC3, 8'hC3, 1'b0, -1, -1);
        tick();
        check("b2b_spacing", last_done_cyc - prev_done_cyc, 18);
        check("b2b_count", done_cnt - d0, 2);

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        // Response compare: match, then a one-bit difference.
        run_op(8'hA5, 8'h5A, 8'h5A, 1'b0, -1, -1);
        run_op(8'hA5, 8'h5B, 8'h5A, 1'b1, -1, -1);
        tick();
        tick();
        check("mismatch_hold", bus.mismatch, 1'b1);
`endif

        tick();
        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
